inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 165 ++++++++++++++++
 tb/tb_inst_encoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: turns format descriptors into instruction words and
// streams them into instruction memory from a base address, with a FULL stop at the top.
module inst_encoder #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_cls,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_alt,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              busy,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   wr_cnt,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;

    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpLoad = 7'b0000011;
    localparam logic [6:0] OpS    = 7'b0100011;
    localparam logic [6:0] OpB    = 7'b1100011;
    localparam logic [6:0] OpLui  = 7'b0110111;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpJalr = 7'b1100111;

    state_e            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [ADDR_W:0]   wr_cnt_q;
    logic [7:0]        err_cnt_q;

    logic        last_addr;
    logic        write_done;
    logic        accept;
    logic [31:0] enc_word;
    logic        enc_legal;

    logic signed [31:0] imm_s;
    logic               fits12;
    logic               fits_b;
    logic               fits_j;
    logic [6:0]         funct7;

    assign imm_s  = $signed(in_imm);
    assign fits12 = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
    assign fits_b = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !in_imm[0];
    assign fits_j = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !in_imm[0];

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        funct7    = 7'b0000000;
        case (in_cls)
            3'd0: begin
                if (in_alt && (in_funct3 == 3'b000 || in_funct3 == 3'b101)) funct7 = 7'b0100000;
                enc_word = {funct7, in_rs2, in_rs1, in_funct3, in_rd, OpR};
            end
            3'd1: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101) begin
                    if (in_alt && in_funct3 == 3'b101) funct7 = 7'b0100000;
                    enc_legal = (in_imm[31:5] == 27'h0);
                    enc_word  = {funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, OpI};
                end else begin
                    enc_legal = fits12;
                    enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OpI};
                end
            end
            3'd2: begin
                enc_legal = fits12;
                enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, OpLoad};
            end
            3'd3: begin
                enc_legal = fits12;
                enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OpS};
            end
            3'd4: begin
                enc_legal = fits_b && (in_funct3 == 3'b000 || in_funct3 == 3'b001 ||
                                       in_funct3 == 3'b100 || in_funct3 == 3'b101);
                enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], OpB};
            end
            3'd5: begin
                enc_legal = (in_imm[11:0] == 12'h0);
                enc_word  = {in_imm[31:12], in_rd, OpLui};
            end
            3'd6: begin
                enc_legal = fits_j;
                enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OpJal};
            end
            3'd7: begin
                enc_legal = fits12;
                enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OpJalr};
            end
        endcase
    end

    assign last_addr  = (addr_q == {ADDR_W{1'b1}});
    assign write_done = we_q && imem_ack;
    // The write at the top address is the last one: nothing may be accepted alongside its ack.
    assign in_ready   = (state_q == StRun) && !start && (!we_q || (imem_ack && !last_addr));
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            wr_cnt_q  <= '0;
            err_cnt_q <= 8'h0;
        end else if (start) begin
            state_q   <= StRun;
            we_q      <= 1'b0;
            addr_q    <= base_addr;
            err_q     <= 1'b0;
            wr_cnt_q  <= '0;
            err_cnt_q <= 8'h0;
        end else begin
            err_q <= 1'b0;
            if (write_done) begin
                we_q     <= 1'b0;
                addr_q   <= addr_q + ADDR_W'(1);
                wr_cnt_q <= wr_cnt_q + (ADDR_W+1)'(1);
                if (last_addr) state_q <= StFull;
            end
            if (accept) begin
                if (enc_legal) begin
                    we_q    <= 1'b1;
                    wdata_q <= enc_word;
                end else begin
                    err_q <= 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign wr_cnt     = wr_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign busy       = (state_q != StIdle);
    assign full       = (state_q == StFull);

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: default-width instance for encoding and handshakes,
// plus an ADDR_W=4 instance that shares the stimulus to exercise the FULL stop.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [13:0] base_addr;
    logic        in_valid;
    logic [2:0]  in_cls;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        in_alt;
    logic [31:0] in_imm;
    logic        imem_ack;

    logic        in_ready, imem_we, busy, full, err;
    logic [13:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [14:0] wr_cnt;
    logic [7:0]  err_cnt;

    logic        s_in_ready, s_imem_we, s_busy, s_full, s_err;
    logic [3:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic [4:0]  s_wr_cnt;
    logic [7:0]  s_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_cls(in_cls), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_alt(in_alt),
        .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ack(imem_ack), .busy(busy), .full(full), .err(err), .wr_cnt(wr_cnt),
        .err_cnt(err_cnt)
    );

    inst_encoder #(.ADDR_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr[3:0]),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_cls(in_cls), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_alt(in_alt),
        .in_imm(in_imm), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
        .imem_wdata(s_imem_wdata), .imem_ack(imem_ack), .busy(s_busy), .full(s_full),
        .err(s_err), .wr_cnt(s_wr_cnt), .err_cnt(s_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                         input logic [31:0] imm);
        in_cls    = cls;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_alt    = alt;
        in_imm    = imm;
        in_valid  = 1'b1;
    endtask

    task automatic do_start(input logic [13:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; imem_ack = 1'b0;
        in_cls = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_alt = 1'b0;
        in_imm = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // addi x1,x0,5 with ack held high
        imem_ack = 1'b1;
        do_start(14'h10);
        check("start_busy", 32'(busy), 32'd1);
        check("start_addr", 32'(imem_addr), 32'h10);
        drive(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
        #1 check("addi_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("addi_we", 32'(imem_we), 32'd1);
        check("addi_addr", 32'(imem_addr), 32'h10);
        check("addi_wdata", imem_wdata, 32'h00500093);
        tick();
        check("addi_we_drop", 32'(imem_we), 32'd0);
        check("addi_wr_cnt", 32'(wr_cnt), 32'd1);
        check("addi_addr_inc", 32'(imem_addr), 32'h11);

        // sub x3,x1,x2 stalled for three cycles, beq queued behind it
        imem_ack = 1'b0;
        drive(3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0);
        tick();
        drive(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, -32'sd4);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sub_we_hold", 32'(imem_we), 32'd1);
            check("sub_wdata_hold", imem_wdata, 32'h402081B3);
            check("sub_addr_hold", 32'(imem_addr), 32'h11);
            check("sub_ready_low", 32'(in_ready), 32'd0);
            tick();
        end
        imem_ack = 1'b1;
        #1 check("sub_ready_on_ack", 32'(in_ready), 32'd1);
        tick();
        check("beq_wdata", imem_wdata, 32'hFE208EE3);
        check("beq_addr", 32'(imem_addr), 32'h12);
        check("beq_wr_cnt", 32'(wr_cnt), 32'd2);
        drive(3'd5, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000);
        tick();
        check("lui_wdata", imem_wdata, 32'h123452B7);
        check("lui_addr", 32'(imem_addr), 32'h13);
        drive(3'd6, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048);
        tick();
        in_valid = 1'b0;
        check("jal_wdata", imem_wdata, 32'h001000EF);
        check("jal_addr", 32'(imem_addr), 32'h14);
        tick();
        check("burst_we_drop", 32'(imem_we), 32'd0);
        check("burst_wr_cnt", 32'(wr_cnt), 32'd5);
        check("burst_addr", 32'(imem_addr), 32'h15);

        // illegal descriptors: addi imm 2048, then odd branch offset
        drive(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2048);
        tick();
        in_valid = 1'b0;
        check("ill_addi_err", 32'(err), 32'd1);
        check("ill_addi_we", 32'(imem_we), 32'd0);
        check("ill_addi_cnt", 32'(err_cnt), 32'd1);
        drive(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd3);
        tick();
        in_valid = 1'b0;
        check("ill_b_err", 32'(err), 32'd1);
        check("ill_b_cnt", 32'(err_cnt), 32'd2);
        check("ill_b_we", 32'(imem_we), 32'd0);
        tick();
        check("ill_err_clear", 32'(err), 32'd0);
        check("ill_addr_same", 32'(imem_addr), 32'h15);
        check("ill_wr_cnt_same", 32'(wr_cnt), 32'd5);

        // srai x1,x2,3
        drive(3'd1, 5'd1, 5'd2, 5'd0, 3'b101, 1'b1, 32'd3);
        tick();
        in_valid = 1'b0;
        check("srai_wdata", imem_wdata, 32'h40315093);
        tick();
        check("srai_wr_cnt", 32'(wr_cnt), 32'd6);

        // start during a pending write, with a simultaneous descriptor
        imem_ack = 1'b0;
        drive(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
        tick();
        check("pend_we", 32'(imem_we), 32'd1);
        start = 1'b1;
        base_addr = 14'h20;
        #1 check("start_prio_ready", 32'(in_ready), 32'd0);
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        check("restart_we", 32'(imem_we), 32'd0);
        check("restart_addr", 32'(imem_addr), 32'h20);
        check("restart_wr_cnt", 32'(wr_cnt), 32'd0);
        check("restart_err_cnt", 32'(err_cnt), 32'd0);
        tick();
        check("restart_no_accept", 32'(imem_we), 32'd0);

        // reset in the middle of a stalled write
        drive(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
        tick();
        in_valid = 1'b0;
        check("mid_we", 32'(imem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_we", 32'(imem_we), 32'd0);
        check("async_rst_addr", 32'(imem_addr), 32'd0);
        check("async_rst_wdata", imem_wdata, 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_we", 32'(imem_we), 32'd0);

        // ADDR_W=4 instance: base 14, three descriptors, third must be held off
        imem_ack = 1'b1;
        do_start(14'd14);
        check("s_start_addr", 32'(s_imem_addr), 32'd14);
        drive(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
        #1 check("s_ready1", 32'(s_in_ready), 32'd1);
        tick();
        check("s_we1", 32'(s_imem_we), 32'd1);
        check("s_addr1", 32'(s_imem_addr), 32'd14);
        drive(3'd1, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 32'd7);
        #1 check("s_ready2", 32'(s_in_ready), 32'd1);
        tick();
        check("s_addr2", 32'(s_imem_addr), 32'd15);
        check("s_wdata2", s_imem_wdata, 32'h00700113);
        check("s_wr_cnt2", 32'(s_wr_cnt), 32'd1);
        drive(3'd1, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 32'd9);
        #1 check("s_ready3_low", 32'(s_in_ready), 32'd0);
        tick();
        check("s_full", 32'(s_full), 32'd1);
        check("s_we_after_full", 32'(s_imem_we), 32'd0);
        check("s_wr_cnt_full", 32'(s_wr_cnt), 32'd2);
        check("s_addr_wrap", 32'(s_imem_addr), 32'd0);
        check("s_ready_full", 32'(s_in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        check("s_held_off_we", 32'(s_imem_we), 32'd0);
        check("s_held_off_cnt", 32'(s_wr_cnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
